// File: rtl/safer_risk_fusion.sv
// -----------------------------------------------------------------------------
// safer_risk_fusion
//
// Fuses NCH per-channel risk scores into one 8-bit risk level. Each channel
// contributes (top 8 bits of its score) * (4-bit weight), one channel per
// cycle, and the sum is scaled by 1/16 and saturated to 255. Alongside the
// fusion, a saturating persistence counter per channel latches a sticky
// critical flag once a channel's score MSB has been set on PERSIST
// consecutive samples.
//
// Optional feature: define SAFER_FUSION_TREND_EN to enable the risk_rising
// trend flag. Without it, risk_rising is tied to 0 and no trend logic exists.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   in_valid      sample offered
//   in_ready      block can accept a sample (high only while idle)
//   in_scores     NCH x SCORE_W scores, channel c at [c*SCORE_W +: SCORE_W]
//   in_weights    NCH x 4-bit unsigned weights, captured with the scores
//   out_valid     result available, held until out_ready
//   out_ready     consumer takes the result
//   risk_level    fused risk, 8 bits
//   alert_flags   per channel the top four score bits {MSB, next three}
//   crit_latched  sticky per-channel critical flags
//   crit_ack      clears the matching crit_latched bits
//   system_ok     registered NOR of crit_latched (one cycle behind it)
//   risk_rising   trend flag for the current result
// -----------------------------------------------------------------------------
module safer_risk_fusion #(
  parameter int NCH         = 4,
  parameter int SCORE_W     = 16,
  parameter int PERSIST     = 3,
  parameter int TREND_DELTA = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*SCORE_W-1:0] in_scores,
  input  logic [NCH*4-1:0]       in_weights,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             risk_level,
  output logic [NCH*4-1:0]       alert_flags,
  output logic [NCH-1:0]         crit_latched,
  input  logic [NCH-1:0]         crit_ack,
  output logic                   system_ok,
  output logic                   risk_rising
);

  // 8-bit top * 4-bit weight is 12 bits; NCH of those need clog2(NCH) more.
  localparam int ACC_W = 12 + $clog2(NCH);
  localparam int IDX_W = $clog2(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [NCH*8-1:0] tops_q;     // only the top byte of each score is ever used
  logic [NCH*4-1:0] weights_q;
  logic [3:0]       cnt [NCH];

  logic             transfer;
  logic [NCH*8-1:0] tops_in;
  logic [7:0]       cur_top;
  logic [3:0]       cur_w;
  logic [11:0]      prod;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-5:0] acc_scaled;
  logic [7:0]       level_sat;
  logic [NCH*4-1:0] alert_next;
  logic [3:0]       cnt_next [NCH];
  logic [NCH-1:0]   set_vec;

  assign transfer = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Datapath: current channel product, running sum and saturated level.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values computed above them; clocked blocks use '<=' so all registers
  // update together from pre-edge values.
  always_comb begin
    // NOTE: every signal gets a value before any branch or loop, so no path
    // leaves one unassigned and no latch is inferred.
    tops_in    = '0;
    alert_next = '0;
    for (int c = 0; c < NCH; c++) begin
      tops_in[c*8 +: 8]    = in_scores[c*SCORE_W + SCORE_W - 8 +: 8];
      alert_next[c*4 +: 4] = tops_q[c*8 + 4 +: 4];
    end
    cur_top    = tops_q[idx*8 +: 8];
    cur_w      = weights_q[idx*4 +: 4];
    prod       = {4'b0000, cur_top} * {8'h00, cur_w};
    acc_sum    = acc + ACC_W'(prod);
    acc_scaled = acc_sum[ACC_W-1:4];
    // ACC_W >= 13, so acc_scaled always has bits above bit 7 to saturate on.
    level_sat  = (|acc_scaled[ACC_W-5:8]) ? 8'hFF : acc_scaled[7:0];
  end

  // ---------------------------------------------------------------------------
  // Persistence: next counter value and which channels reach PERSIST.
  // ---------------------------------------------------------------------------
  always_comb begin
    set_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      cnt_next[c] = 4'd0;
      if (tops_in[c*8 + 7]) begin
        cnt_next[c] = (cnt[c] == 4'hF) ? 4'hF : cnt[c] + 4'd1;
      end
      set_vec[c] = (cnt_next[c] >= 4'(PERSIST));
    end
  end

  // Sample capture. These registers are always written by a transfer before
  // the accumulator reads them.
  // NOTE: the captured sample has no reset: it is overwritten on every
  // transfer before use, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (transfer) begin
      tops_q    <= tops_in;
      weights_q <= in_weights;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      risk_level  <= 8'h00;
      alert_flags <= '0;
      acc         <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (transfer) begin
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Publish using the sum that already includes the last channel.
            risk_level  <= level_sat;
            alert_flags <= alert_next;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Persistence counters, sticky critical flags and system_ok.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is only NCH small registers, so it is reset
      // element by element like ordinary flops rather than left as memory.
      for (int c = 0; c < NCH; c++) begin
        cnt[c] <= 4'd0;
      end
      crit_latched <= '0;
      system_ok    <= 1'b0;
    end else begin
      if (transfer) begin
        for (int c = 0; c < NCH; c++) begin
          cnt[c] <= cnt_next[c];
        end
      end
      // Set is OR-ed in after the ack mask, so a same-cycle set wins.
      crit_latched <= (crit_latched & ~crit_ack) | (transfer ? set_vec : '0);
      system_ok    <= ~|crit_latched;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional trend flag.
  // ---------------------------------------------------------------------------
`ifdef SAFER_FUSION_TREND_EN
  logic              done_entry;
  logic [7:0]        prev_level;
  logic signed [9:0] level_diff;

  assign done_entry = (state == ACCUM) && (idx == LAST_IDX);
  assign level_diff = signed'({2'b00, level_sat}) - signed'({2'b00, prev_level});

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level  <= 8'h00;
      risk_rising <= 1'b0;
    end else if (done_entry) begin
      prev_level  <= level_sat;
      risk_rising <= (int'(level_diff) > TREND_DELTA);
    end
  end
`else
  assign risk_rising = 1'b0;
`endif

endmodule

// File: tb/tb_safer_risk_fusion.sv
// -----------------------------------------------------------------------------
// tb_safer_risk_fusion
//
// Directed bench for safer_risk_fusion with default parameters (NCH=4,
// SCORE_W=16, PERSIST=3, TREND_DELTA=16). Inputs are driven on the falling
// edge and outputs sampled on the falling edge. Trend expectations follow
// SAFER_FUSION_TREND_EN: with it undefined, risk_rising must stay 0.
// -----------------------------------------------------------------------------
module tb_safer_risk_fusion;

  localparam int NCH     = 4;
  localparam int SCORE_W = 16;
`ifdef SAFER_FUSION_TREND_EN
  localparam bit TREND_EN = 1'b1;
`else
  localparam bit TREND_EN = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [NCH*SCORE_W-1:0] in_scores;
  logic [NCH*4-1:0]       in_weights;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             risk_level;
  logic [NCH*4-1:0]       alert_flags;
  logic [NCH-1:0]         crit_latched;
  logic [NCH-1:0]         crit_ack;
  logic                   system_ok;
  logic                   risk_rising;

  safer_risk_fusion #(
    .NCH(NCH), .SCORE_W(SCORE_W), .PERSIST(3), .TREND_DELTA(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_scores(in_scores), .in_weights(in_weights),
    .out_valid(out_valid), .out_ready(out_ready),
    .risk_level(risk_level), .alert_flags(alert_flags),
    .crit_latched(crit_latched), .crit_ack(crit_ack),
    .system_ok(system_ok), .risk_rising(risk_rising)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int t_xfer   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Top byte per channel; the low byte is filler that must not matter.
  function automatic logic [NCH*SCORE_W-1:0] mk_scores(input logic [7:0] t0, input logic [7:0] t1,
                                                      input logic [7:0] t2, input logic [7:0] t3);
    return {t3, 8'h5A, t2, 8'h5A, t1, 8'h5A, t0, 8'h5A};
  endfunction

  // Offer a sample, wait (bounded) for in_ready, complete the transfer edge.
  task automatic start_transfer(input string tag, input logic [NCH*SCORE_W-1:0] s,
                                input logic [NCH*4-1:0] w);
    int n = 0;
    in_scores  = s;
    in_weights = w;
    in_valid   = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    tick();
    t_xfer   = cyc;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and check latency and result outputs.
  task automatic check_result(input string tag, input logic [7:0] lvl,
                              input logic [15:0] alert, input logic rise);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    // Transfer cycle T ends at edge t_xfer; out_valid is visible in cycle
    // T+NCH+1, i.e. NCH edges later.
    check({tag, " latency"}, cyc - t_xfer, NCH);
    check({tag, " risk_level"}, risk_level, lvl);
    check({tag, " alert_flags"}, alert_flags, alert);
    check({tag, " risk_rising"}, risk_rising, TREND_EN & rise);
  endtask

  // With out_ready high, DONE lasts one cycle and the block is ready again.
  task automatic finish_result(input string tag);
    tick();
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_scores  = '0;
    in_weights = '0;
    out_ready  = 1'b1;
    crit_ack   = '0;

    // ---- Reset state ----
    tick(); tick(); tick();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst risk_level", risk_level, 0);
    check("rst alert_flags", alert_flags, 0);
    check("rst crit_latched", crit_latched, 0);
    check("rst system_ok", system_ok, 0);
    check("rst risk_rising", risk_rising, 0);
    rst = 1'b0;
    tick();
    check("post-rst in_ready", in_ready, 1);
    check("post-rst system_ok", system_ok, 1);

    // ---- B: saturation, all tops 0xFF, weights 15: 4*255*15>>4 = 956 -> 0xFF ----
    start_transfer("B", mk_scores(8'hFF, 8'hFF, 8'hFF, 8'hFF), 16'hFFFF);
    check_result("B", 8'hFF, 16'hFFFF, 1'b1);
    check("B crit_latched", crit_latched, 0);
    finish_result("B");

    // ---- A: tops 0x40, weights 4: 4*64*4>>4 = 0x40; clears counters ----
    start_transfer("A", mk_scores(8'h40, 8'h40, 8'h40, 8'h40), 16'h4444);
    check_result("A", 8'h40, 16'h4444, 1'b0);
    finish_result("A");

    // ---- C: channel 2 MSB on three samples; (3*16+128)>>4 = 0x0B ----
    start_transfer("C1", mk_scores(8'h10, 8'h10, 8'h80, 8'h10), 16'h1111);
    check("C1 crit_latched", crit_latched, 0);
    check_result("C1", 8'h0B, 16'h1811, 1'b0);
    finish_result("C1");

    start_transfer("C2", mk_scores(8'h10, 8'h10, 8'h80, 8'h10), 16'h1111);
    check("C2 crit_latched", crit_latched, 0);
    check_result("C2", 8'h0B, 16'h1811, 1'b0);
    finish_result("C2");

    // Ack on ch2 in the same cycle as the setting transfer: set wins.
    crit_ack = 4'b0100;
    start_transfer("C3", mk_scores(8'h10, 8'h10, 8'h80, 8'h10), 16'h1111);
    crit_ack = 4'b0000;
    check("C3 crit_latched", crit_latched, 4'b0100);
    check("C3 system_ok lag", system_ok, 1);
    tick();
    check("C3 system_ok low", system_ok, 0);
    check_result("C3", 8'h0B, 16'h1811, 1'b0);
    finish_result("C3");

    crit_ack = 4'b0100;
    tick();
    crit_ack = 4'b0000;
    check("C ack crit_latched", crit_latched, 0);
    check("C ack system_ok lag", system_ok, 0);
    tick();
    check("C ack system_ok", system_ok, 1);

    // ---- D: back-pressure for 10 cycles; 4*32*2>>4 = 0x10 ----
    out_ready = 1'b0;
    start_transfer("D1", mk_scores(8'h20, 8'h20, 8'h20, 8'h20), 16'h2222);
    // Keep offering the next sample (4*48*2>>4 = 0x18) during the stall.
    in_scores  = mk_scores(8'h30, 8'h30, 8'h30, 8'h30);
    in_weights = 16'h2222;
    in_valid   = 1'b1;
    check_result("D1", 8'h10, 16'h2222, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("D stall out_valid", out_valid, 1);
      check("D stall in_ready", in_ready, 0);
      check("D stall risk_level", risk_level, 8'h10);
      check("D stall alert_flags", alert_flags, 16'h2222);
    end
    out_ready = 1'b1;
    tick();
    check("D handshake out_valid", out_valid, 0);
    check("D handshake in_ready", in_ready, 1);
    tick();
    t_xfer   = cyc;
    in_valid = 1'b0;
    check("D2 accepted", in_ready, 0);
    check_result("D2", 8'h18, 16'h3333, 1'b0);
    finish_result("D2");

    // ---- E: trend, 0x10 then 0x30 (rise of 32 > 16) ----
    start_transfer("E1", mk_scores(8'h10, 8'h10, 8'h10, 8'h10), 16'h4444);
    check_result("E1", 8'h10, 16'h1111, 1'b0);
    finish_result("E1");
    start_transfer("E2", mk_scores(8'h30, 8'h30, 8'h30, 8'h30), 16'h4444);
    check_result("E2", 8'h30, 16'h3333, 1'b1);
    finish_result("E2");

    // ---- F: reset during ACCUM cycle 2 discards the sample ----
    start_transfer("F", mk_scores(8'h40, 8'h40, 8'h40, 8'h40), 16'h4444);
    tick();
    rst = 1'b1;
    tick();
    check("F rst out_valid", out_valid, 0);
    check("F rst in_ready", in_ready, 0);
    check("F rst risk_level", risk_level, 0);
    check("F rst alert_flags", alert_flags, 0);
    check("F rst crit_latched", crit_latched, 0);
    check("F rst system_ok", system_ok, 0);
    check("F rst risk_rising", risk_rising, 0);
    rst = 1'b0;
    tick();
    check("F release in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("F no out_valid", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
